mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the variable-latency single-port RAM.
- Shares the RAM between the instruction-fetch port (read-only) and the data port (read/write).
- Holds one grant stable until the RAM reports ACCESS, then acknowledges that requester.
- Round-robin when both ports contend; includes a watchdog that flags stuck or illegal RAM transactions.

Parameters:
TIMEOUT, 64, cycles a grant may wait for ACCESS before the sticky timeout flag is set (counter width clog2(TIMEOUT)+1)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction word address
iload  output  32  instruction read data, valid when iwait=0
iwait  output  1  0 for exactly the completing cycle of an instruction access
dREN  input  1  data read request
dWEN  input  1  data write request (wins if dREN also high)
daddr  input  32  data word address
dstore  input  32  data write value
dload  output  32  data read data, valid when dwait=0
dwait  output  1  0 for exactly the completing cycle of a data access
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR from mem_types_pkg)
timeout  output  1  sticky: a grant exceeded TIMEOUT cycles
ram_err  output  1  sticky: ramstate==ERROR observed while a grant was active

Behaviour:
- Reset is asynchronous, active-low. Reset values: state IDLE, last_d=0, wait counter 0, timeout=0, ram_err=0.
- Outputs during reset: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1.
- iload and dload are always a combinational passthrough of ramload; they are meaningful only when the matching wait is 0.
- States:
  - IDLE: nothing driven to the RAM (REN=WEN=0, addr=0, store=0).
  - SERVE_I: ramREN=1, ramWEN=0, ramaddr=iaddr (combinational passthrough).
  - SERVE_D: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore. The arbiter never drives REN and WEN together.
- Grant selection in IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not served last is granted (last_d=0 means data wins first).
  - The state moves on the next edge. No request: remain in IDLE.
- Completion in SERVE_x when ramstate==ACCESS:
  - Same cycle: xwait=0, the other wait stays 1, last_d is updated.
  - Next state is SERVE of the other port if it is requesting, else IDLE. There is no extra turnaround cycle.
- Withdrawal: if the granted port drops its request (or data drops both REN and WEN) before ACCESS, return to IDLE next edge with no acknowledge. last_d is unchanged.
- Address or data changes mid-grant are forwarded as-is; the RAM restarts its latency.
- Latency with RAM LAT: a request sampled in IDLE is acknowledged LAT+2 cycles later. A chained grant completes LAT+2 cycles after the previous acknowledge.
- Back-to-back reads to the same address with the same enable type may complete in the first cycle of the chained grant. This is legal: the data is the same word.
- Wait counter:
  - Clears on every state change and on every acknowledge.
  - Increments each SERVE cycle without ACCESS and saturates.
  - Reaching TIMEOUT sets timeout (sticky until reset). The grant is not aborted.
- ram_err sets on ramstate==ERROR in SERVE_I or SERVE_D and stays set until reset. ERROR in IDLE is ignored.
- iwait=1 and dwait=1 in every cycle except the acknowledge cycle defined above.
- Reset mid-grant: immediate return to IDLE, no acknowledge. The ACCESS reported by the RAM while nRST=0 is ignored.

Test Plan:
- Single fetch, RAM LAT=6: iREN=1, iaddr=0x40 held. Required: ramREN=1 with ramaddr=0x40 from cycle 1; iwait=0 only in cycle 8; iload equals word 0x40; then IDLE.
- Data write then read, LAT=6: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, acknowledged in cycle 8; then dREN=1 at the same address. Required: dload=0xDEADBEEF on the second acknowledge; ramREN and ramWEN never high together.
- Contention from reset: iREN and dREN both high at cycle 0 with differing addresses. Required: data acknowledged in cycle 8, fetch acknowledged in cycle 16 with no IDLE gap; next contention grants data first again.
- Withdrawal: iREN dropped in cycle 4 of SERVE_I while dREN is high. Required: no iwait=0 pulse; IDLE in cycle 5, then SERVE_D; last_d unchanged.
- Watchdog with TIMEOUT=8: stub RAM holds BUSY for 20 cycles and then returns ACCESS. Required: timeout=1 from cycle 9 after the grant and remains 1; the access still completes.
- Async reset asserted mid-SERVE_D. Required: immediately ramWEN=0, dwait=1, timeout=ram_err=0; after release a fresh request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a variable-latency single-port RAM.
// Round-robin on contention, grant held until ACCESS, sticky watchdog and error flags.
package mem_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// state   | meaning
// IDLE    | no grant, RAM interface quiet
// SERVE_I | fetch port granted, waiting for ACCESS
// SERVE_D | data port granted, waiting for ACCESS
module mem_arbiter
  import mem_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        timeout,
  output logic        ram_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t          state, state_nxt;
  logic            last_d, last_d_nxt;
  logic [CW-1:0]   wcnt, wcnt_nxt;
  logic            ack;
  logic            d_req;
  logic            serving;

  assign d_req   = dREN | dWEN;
  assign serving = (state != IDLE);
  assign iload   = ramload;
  assign dload   = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      wcnt    <= '0;
      timeout <= 1'b0;
      ram_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      wcnt    <= wcnt_nxt;
      timeout <= timeout | (serving && (wcnt_nxt >= CW'(TIMEOUT)));
      ram_err <= ram_err | (serving && (ramstate == ERROR));
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        // last_d=1 means data was served last, so fetch wins a tie
        if (d_req && (!iREN || !last_d)) state_nxt = SERVE_D;
        else if (iREN)                   state_nxt = SERVE_I;
      end
      SERVE_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait      = 1'b0;
          ack        = 1'b1;
          last_d_nxt = 1'b0;
          state_nxt  = d_req ? SERVE_D : IDLE;
        end
      end
      SERVE_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          ack        = 1'b1;
          last_d_nxt = 1'b1;
          state_nxt  = iREN ? SERVE_I : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    wcnt_nxt = wcnt;
    if (!serving || ack || (state_nxt != state)) wcnt_nxt = '0;
    else if (wcnt != '1)                         wcnt_nxt = wcnt + CW'(1);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM with restartable latency, scoreboard of expected
// acknowledges (port, cycle, data) checked by an independent monitor.
module tb_mem_arbiter;
  import mem_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, timeout, ram_err;
  ramstate_t   ramstate;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // RAM model: ACCESS once the same request has been held for lat+1 preceding cycles
  logic [31:0] mem [1024];
  int          c;
  bit          pv;
  logic [32:0] preq;
  int          lat = 6;
  bit          force_err = 0;
  bit          force_acc = 0;
  logic        en;

  assign en      = ramREN | ramWEN;
  assign ramload = mem[ramaddr[9:0]];

  always_comb begin
    if (force_err)          ramstate = ERROR;
    else if (force_acc)     ramstate = ACCESS;
    else if (!en)           ramstate = FREE;
    else if (c == lat + 1)  ramstate = ACCESS;
    else                    ramstate = BUSY;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h040] = 32'h12345678;
    mem[10'h200] = 32'hA5A5A5A5;
    mem[10'h300] = 32'h0BADF00D;
    mem[10'h180] = 32'h55555555;
    c    = 0;
    pv   = 0;
    preq = '0;
    forever begin
      @(posedge CLK);
      if (ramstate == ACCESS || !en) begin
        if (ramstate == ACCESS && ramWEN) mem[ramaddr[9:0]] <= ramstore;
        c  <= 0;
        pv <= 0;
      end else begin
        if (pv && preq == {ramWEN, ramaddr}) c <= c + 1;
        else                                 c <= 1;
        pv   <= 1;
        preq <= {ramWEN, ramaddr};
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic void expect_ack(input bit is_d, input bit chk_data, input logic [31:0] data,
                                     input int at);
    exp_t e;
    e.is_d = is_d; e.chk_data = chk_data; e.data = data; e.cyc = at;
    sbq.push_back(e);
  endfunction

  always @(negedge CLK) begin
    if (nRST) begin
      checks++;
      if (ramREN && ramWEN) begin
        errors++;
        $display("FAIL ren_wen_excl: both enables high at cycle %0d, required at most one", cyc);
      end
      if (!iwait || !dwait) begin
        checks++;
        if (!iwait && !dwait) begin
          errors++;
          $display("FAIL double_ack: iwait=0 and dwait=0 at cycle %0d, required one at most", cyc);
        end else if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: %s ack at cycle %0d, none expected",
                   !dwait ? "data" : "fetch", cyc);
        end else begin
          mon_e = sbq.pop_front();
          if ((mon_e.is_d != !dwait) || (mon_e.cyc != cyc) ||
              (mon_e.chk_data && ((!dwait ? dload : iload) !== mon_e.data))) begin
            errors++;
            $display("FAIL ack: got port=%s cycle=%0d data=%h, required port=%s cycle=%0d data=%h",
                     !dwait ? "d" : "i", cyc, !dwait ? dload : iload,
                     mon_e.is_d ? "d" : "i", mon_e.cyc, mon_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_ack(input bit is_d, input int lim);
    bit seen = 0;
    int n = 0;
    while (!seen && n < lim) begin
      @(negedge CLK);
      seen = is_d ? !dwait : !iwait;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: no %s ack within %0d cycles (cycle %0d)", is_d ? "data" : "fetch", lim, cyc);
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: bench did not finish, cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  int t0, t1;

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (3) tick();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_timeout", timeout, 0);
    chk("rst_ram_err", ram_err, 0);
    nRST = 1;
    tick();

    // single fetch
    t0 = cyc;
    iREN = 1; iaddr = 32'h40;
    expect_ack(0, 1, 32'h12345678, t0 + 8);
    go(t0 + 1); @(negedge CLK);
    chk("fetch_ramREN", ramREN, 1);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    wait_ack(0, 12);
    iREN = 0;
    @(negedge CLK);
    chk("fetch_idle_ramREN", ramREN, 0);
    chk("fetch_idle_ramaddr", ramaddr, 0);

    // data write then read back
    tick();
    t0 = cyc;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    expect_ack(1, 0, 32'h0, t0 + 8);
    go(t0 + 1); @(negedge CLK);
    chk("write_ramWEN", ramWEN, 1);
    chk("write_ramstore", ramstore, 32'hDEADBEEF);
    wait_ack(1, 12);
    t1 = cyc;
    dWEN = 0; dREN = 1;
    expect_ack(1, 1, 32'hDEADBEEF, t1 + 8);
    wait_ack(1, 12);
    dREN = 0;

    // contention from reset: data first, fetch chained without gap, then data first again
    nRST = 0; tick(); tick(); nRST = 1; tick();
    t0 = cyc;
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
    expect_ack(1, 1, 32'h0BADF00D, t0 + 8);
    expect_ack(0, 1, 32'hA5A5A5A5, t0 + 16);
    wait_ack(1, 12);
    dREN = 0;
    wait_ack(0, 12);
    iREN = 0;
    t1 = cyc;
    iREN = 1; dREN = 1;
    expect_ack(1, 1, 32'h0BADF00D, t1 + 8);
    expect_ack(0, 1, 32'hA5A5A5A5, t1 + 16);
    wait_ack(1, 12);
    dREN = 0;
    wait_ack(0, 12);
    iREN = 0;

    // withdrawal of the fetch grant while data is waiting
    t0 = cyc;
    iREN = 1; iaddr = 32'h200;
    go(t0 + 2);
    dREN = 1; daddr = 32'h300;
    expect_ack(1, 1, 32'h0BADF00D, t0 + 13);
    go(t0 + 4);
    iREN = 0;
    go(t0 + 5); @(negedge CLK);
    chk("withdraw_idle_ramREN", ramREN, 0);
    go(t0 + 6); @(negedge CLK);
    chk("withdraw_serve_d_ramREN", ramREN, 1);
    chk("withdraw_serve_d_ramaddr", ramaddr, 32'h300);
    wait_ack(1, 12);
    dREN = 0;

    // data served last, so fetch wins this contention
    t1 = cyc;
    iREN = 1; dREN = 1;
    expect_ack(0, 1, 32'hA5A5A5A5, t1 + 8);
    expect_ack(1, 1, 32'h0BADF00D, t1 + 16);
    wait_ack(0, 12);
    iREN = 0;
    wait_ack(1, 12);
    dREN = 0;

    // ERROR in IDLE ignored; watchdog with long latency; ERROR mid-grant
    force_err = 1;
    tick();
    force_err = 0;
    @(negedge CLK);
    chk("idle_err_ignored", ram_err, 0);
    tick();
    lat = 19;
    t0 = cyc;
    dREN = 1; daddr = 32'h100;
    expect_ack(1, 1, 32'hDEADBEEF, t0 + 21);
    go(t0 + 8); @(negedge CLK);
    chk("timeout_before", timeout, 0);
    go(t0 + 9); @(negedge CLK);
    chk("timeout_set", timeout, 1);
    go(t0 + 12);
    force_err = 1;
    go(t0 + 13);
    force_err = 0;
    @(negedge CLK);
    chk("serve_err_set", ram_err, 1);
    wait_ack(1, 15);
    dREN = 0;
    @(negedge CLK);
    chk("timeout_sticky", timeout, 1);
    chk("ram_err_sticky", ram_err, 1);

    // async reset mid-SERVE_D, ACCESS during reset ignored, then a fresh request
    lat = 6;
    tick();
    t0 = cyc;
    dWEN = 1; daddr = 32'h180; dstore = 32'hCAFEF00D;
    go(t0 + 3);
    #2;
    nRST = 0; force_acc = 1; dWEN = 0;
    #1;
    chk("areset_ramWEN", ramWEN, 0);
    chk("areset_ramaddr", ramaddr, 0);
    chk("areset_dwait", dwait, 1);
    chk("areset_timeout", timeout, 0);
    chk("areset_ram_err", ram_err, 0);
    @(negedge CLK);
    chk("areset_acc_dwait", dwait, 1);
    chk("areset_acc_iwait", iwait, 1);
    tick(); tick();
    force_acc = 0;
    nRST = 1;
    tick();
    t1 = cyc;
    iREN = 1; iaddr = 32'h180;
    expect_ack(0, 1, 32'h55555555, t1 + 8);
    wait_ack(0, 12);
    iREN = 0;
    tick();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
